rtc_lapctrl: RTL

- Run-control and lap scheduler for the stopwatch 24-bit BCD counter chain.
- Turns debounced start/stop and lap/reset button pulses into the counter's enable, init and latch controls.
- Captures lap times into a small circular buffer and chooses what the display shows: live count, a held lap, or a recalled lap.
- Sits between the button front-end and the counter/display path.

---
 rtl/rtc_pkg.sv | 24 ++
 rtl/rtc_lapbuffer.sv | 51 +++++
 rtl/rtc_lapctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared types and width helpers for the stopwatch run-control / lap scheduler.
// Pure declarations; no logic.
package rtc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STOP   = 2'd2,
      RECALL = 2'd3
   } state_t;

   localparam int CW_DEF        = 24;
   localparam int LAP_DEPTH_DEF = 4;
   localparam int LAP_HOLD_DEF  = 200;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rtc_lapbuffer.sv
// Circular lap store: write/clear take effect next cycle, read is combinational
// relative to the oldest entry; no backpressure, a write when full overwrites the oldest.
module rtc_lapbuffer
   import rtc_pkg::*;
#(
   parameter  int CW        = CW_DEF,
   parameter  int LAP_DEPTH = LAP_DEPTH_DEF,
   localparam int PW        = ptr_w(LAP_DEPTH),
   localparam int NW        = cnt_w(LAP_DEPTH)
) (
   input  logic          core_clk,
   input  logic          arst_n,
   input  logic          wr_vld,
   input  logic [CW-1:0] wr_dat,
   input  logic          clr,
   input  logic [PW-1:0] rd_idx,
   output logic [CW-1:0] rd_dat,
   output logic [NW-1:0] lap_cnt
);

   logic [CW-1:0] mem [LAP_DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr_base;
   logic [PW-1:0] rd_ptr;
   logic          full;

   assign full   = (lap_cnt == NW'(LAP_DEPTH));
   // Pointer width equals log2(depth), so the add wraps modulo LAP_DEPTH for free.
   assign rd_ptr = rptr_base + rd_idx;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         wptr      <= '0;
         rptr_base <= '0;
         lap_cnt   <= '0;
         for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wptr      <= '0;
         rptr_base <= '0;
         lap_cnt   <= '0;
         for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
      end else if (wr_vld) begin
         mem[wptr] <= wr_dat;
         wptr      <= wptr + PW'(1);
         if (full) rptr_base <= rptr_base + PW'(1);
         else      lap_cnt   <= lap_cnt + NW'(1);
      end
   end

endmodule

// File: rtl/rtc_lapctrl.sv
// Stopwatch run-control FSM, lap hold timer and display mux over the lap buffer.
// All outputs registered: one cycle after the button pulse; no backpressure, startstop wins over lapreset.
module rtc_lapctrl
   import rtc_pkg::*;
#(
   parameter int CW        = CW_DEF,
   parameter int LAP_DEPTH = LAP_DEPTH_DEF,
   parameter int LAP_HOLD  = LAP_HOLD_DEF
) (
   input  logic                         i_rtcclk,
   input  logic                         i_reset_n,
   input  logic                         i_startstop,
   input  logic                         i_lapreset,
   input  logic [CW-1:0]                i_count,
   output logic                         o_countenb,
   output logic                         o_countinit,
   output logic                         o_latchcount,
   output logic [CW-1:0]                o_dispcount,
   output logic [ptr_w(LAP_DEPTH)-1:0]  o_lapidx,
   output logic [cnt_w(LAP_DEPTH)-1:0]  o_lapcnt,
   output logic                         o_running
);

   localparam int PW = ptr_w(LAP_DEPTH);
   localparam int NW = cnt_w(LAP_DEPTH);
   localparam int HW = $clog2(LAP_HOLD + 1);

   state_t        state, state_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [PW-1:0] idx_nxt;
   logic          start_p, lap_p;
   logic          capture, buf_clr, init_nxt;
   logic [CW-1:0] rd_dat;

   assign start_p = i_startstop;
   assign lap_p   = i_lapreset & ~i_startstop;

   rtc_lapbuffer #(.CW(CW), .LAP_DEPTH(LAP_DEPTH)) u_lapbuffer (
      .core_clk (i_rtcclk),
      .arst_n   (i_reset_n),
      .wr_vld   (capture),
      .wr_dat   (i_count),
      .clr      (buf_clr),
      .rd_idx   (idx_nxt),
      .rd_dat   (rd_dat),
      .lap_cnt  (o_lapcnt)
   );

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      idx_nxt   = o_lapidx;
      capture   = 1'b0;
      buf_clr   = 1'b0;
      init_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start_p) state_nxt = RUN;
         end
         RUN: begin
            if (hold_cnt != '0) hold_nxt = hold_cnt - HW'(1);
            if (start_p) begin
               state_nxt = STOP;
               hold_nxt  = '0;
            end else if (lap_p) begin
               capture  = 1'b1;
               hold_nxt = HW'(LAP_HOLD);
            end
         end
         STOP: begin
            if (start_p) begin
               state_nxt = RUN;
            end else if (lap_p) begin
               if (o_lapcnt != '0) begin
                  state_nxt = RECALL;
                  idx_nxt   = '0;
               end else begin
                  state_nxt = IDLE;
                  init_nxt  = 1'b1;
                  buf_clr   = 1'b1;
               end
            end
         end
         RECALL: begin
            if (start_p) begin
               state_nxt = STOP;
               idx_nxt   = '0;
            end else if (lap_p) begin
               // Stepping past the newest lap ends the session and clears everything.
               if ({1'b0, o_lapidx} == o_lapcnt - NW'(1)) begin
                  state_nxt = IDLE;
                  init_nxt  = 1'b1;
                  buf_clr   = 1'b1;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = o_lapidx + PW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         o_lapidx    <= '0;
         o_countinit <= 1'b0;
         o_dispcount <= '0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_nxt;
         o_lapidx    <= idx_nxt;
         o_countinit <= init_nxt;
         if (capture)                   o_dispcount <= i_count;
         else if (hold_nxt != '0)       o_dispcount <= o_dispcount;
         else if (state_nxt == RECALL)  o_dispcount <= rd_dat;
         else                           o_dispcount <= i_count;
      end
   end

   assign o_countenb   = (state == RUN);
   assign o_running    = (state == RUN);
   assign o_latchcount = (hold_cnt != '0) || (state == RECALL);

endmodule
